// File: rtl/bus_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : bus_copy_master
// Brief    : Bus initiator that copies a block of 64-bit words from a source
//            address range to a destination range in buffered bursts.
//            Optional feature macro: BUS_COPY_GRANT_CHECK_EN (grant-loss abort,
//            adds the sticky err output).
// Revision : 1.0  initial release
// ============================================================================
module bus_copy_master #(
    parameter int BUF_DEPTH = 4,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
`ifdef BUS_COPY_GRANT_CHECK_EN
    output logic             err,
`endif
    output logic             m_req,
    input  logic             m_grant,
    output logic             m_wr,
    output logic [15:0]      m_addr,
    output logic [63:0]      m_dout,
    input  logic [63:0]      m_din
);

    localparam int c_IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [LEN_W-1:0]   c_LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0]   c_LEN_BUF = LEN_W'(BUF_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD      = 3'd2,
        S_RD_TAIL = 3'd3,
        S_WR      = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t             r_state_q,   w_state_d;
    logic               r_busy_q,    w_busy_d;
    logic               r_done_q,    w_done_d;
    logic               r_m_req_q,   w_m_req_d;
    logic               r_m_wr_q,    w_m_wr_d;
    logic [15:0]        r_m_addr_q,  w_m_addr_d;
    logic [63:0]        r_m_dout_q,  w_m_dout_d;
    logic [15:0]        r_src_ptr_q, w_src_ptr_d;
    logic [15:0]        r_dst_ptr_q, w_dst_ptr_d;
    logic [LEN_W-1:0]   r_rem_q,     w_rem_d;
    logic [c_CNT_W-1:0] r_chunk_q,   w_chunk_d;
    logic [c_CNT_W-1:0] r_idx_q,     w_idx_d;
    logic [63:0]        r_buf_q [BUF_DEPTH];
    logic [63:0]        w_buf_d [BUF_DEPTH];
`ifdef BUS_COPY_GRANT_CHECK_EN
    logic               r_err_q,     w_err_d;
`endif

    logic [c_CNT_W-1:0] w_idx_prev;
    logic [c_CNT_W-1:0] w_idx_next;
    logic [c_CNT_W-1:0] w_chunk_last;

    assign w_idx_prev   = r_idx_q - c_CNT_ONE;
    assign w_idx_next   = r_idx_q + c_CNT_ONE;
    assign w_chunk_last = r_chunk_q - c_CNT_ONE;

    function automatic logic [c_CNT_W-1:0] f_chunk(input logic [LEN_W-1:0] r);
        if (r >= c_LEN_BUF) begin
            return c_DEPTH;
        end
        return c_CNT_W'(r);
    endfunction

    always_comb begin
        w_state_d   = r_state_q;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;
        w_m_req_d   = r_m_req_q;
        w_m_wr_d    = r_m_wr_q;
        w_m_addr_d  = r_m_addr_q;
        w_m_dout_d  = r_m_dout_q;
        w_src_ptr_d = r_src_ptr_q;
        w_dst_ptr_d = r_dst_ptr_q;
        w_rem_d     = r_rem_q;
        w_chunk_d   = r_chunk_q;
        w_idx_d     = r_idx_q;
        w_buf_d     = r_buf_q;
`ifdef BUS_COPY_GRANT_CHECK_EN
        w_err_d     = r_err_q;
`endif

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
`ifdef BUS_COPY_GRANT_CHECK_EN
                    w_err_d = 1'b0;
`endif
                    if (len != '0) begin
                        w_src_ptr_d = src_addr;
                        w_dst_ptr_d = dst_addr;
                        w_rem_d     = len;
                        w_busy_d    = 1'b1;
                        w_m_req_d   = 1'b1;
                        w_m_wr_d    = 1'b0;
                        w_state_d   = S_REQ;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
            end

            S_REQ: begin
                if (m_grant) begin
                    w_chunk_d   = f_chunk(r_rem_q);
                    w_m_addr_d  = r_src_ptr_q;
                    w_src_ptr_d = r_src_ptr_q + 16'd1;
                    w_idx_d     = '0;
                    w_state_d   = S_RD;
                end
            end

            // Slave data lags the address by one cycle, so cycle k captures word k-1.
            S_RD: begin
                if (r_idx_q != '0) begin
                    w_buf_d[w_idx_prev[c_IDX_W-1:0]] = m_din;
                end
                if (r_idx_q == w_chunk_last) begin
                    w_state_d = S_RD_TAIL;
                end else begin
                    w_m_addr_d  = r_src_ptr_q;
                    w_src_ptr_d = r_src_ptr_q + 16'd1;
                    w_idx_d     = w_idx_next;
                end
            end

            // A one-word chunk has not reached the buffer yet, so bypass m_din.
            S_RD_TAIL: begin
                w_buf_d[r_idx_q[c_IDX_W-1:0]] = m_din;
                w_m_addr_d  = r_dst_ptr_q;
                w_m_wr_d    = 1'b1;
                w_m_dout_d  = (r_chunk_q == c_CNT_ONE) ? m_din : r_buf_q[0];
                w_dst_ptr_d = r_dst_ptr_q + 16'd1;
                w_rem_d     = r_rem_q - c_LEN_ONE;
                w_idx_d     = '0;
                w_state_d   = S_WR;
            end

            S_WR: begin
                if (r_idx_q != w_chunk_last) begin
                    w_m_addr_d  = r_dst_ptr_q;
                    w_m_dout_d  = r_buf_q[w_idx_next[c_IDX_W-1:0]];
                    w_dst_ptr_d = r_dst_ptr_q + 16'd1;
                    w_rem_d     = r_rem_q - c_LEN_ONE;
                    w_idx_d     = w_idx_next;
                end else if (r_rem_q != '0) begin
                    // Next burst starts immediately; the bus is kept, no re-request.
                    w_chunk_d   = f_chunk(r_rem_q);
                    w_m_wr_d    = 1'b0;
                    w_m_addr_d  = r_src_ptr_q;
                    w_src_ptr_d = r_src_ptr_q + 16'd1;
                    w_idx_d     = '0;
                    w_state_d   = S_RD;
                end else begin
                    w_m_req_d = 1'b0;
                    w_m_wr_d  = 1'b0;
                    w_done_d  = 1'b1;
                    w_busy_d  = 1'b0;
                    w_state_d = S_FIN;
                end
            end

            S_FIN: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase

`ifdef BUS_COPY_GRANT_CHECK_EN
        if (!m_grant && (r_state_q == S_RD || r_state_q == S_RD_TAIL || r_state_q == S_WR)) begin
            w_m_req_d = 1'b0;
            w_m_wr_d  = 1'b0;
            w_err_d   = 1'b1;
            w_done_d  = 1'b1;
            w_busy_d  = 1'b0;
            w_state_d = S_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= S_IDLE;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
            r_m_req_q   <= 1'b0;
            r_m_wr_q    <= 1'b0;
            r_m_addr_q  <= 16'h0000;
            r_m_dout_q  <= 64'h0;
            r_src_ptr_q <= 16'h0000;
            r_dst_ptr_q <= 16'h0000;
            r_rem_q     <= '0;
            r_chunk_q   <= '0;
            r_idx_q     <= '0;
            r_buf_q     <= '{default: '0};
`ifdef BUS_COPY_GRANT_CHECK_EN
            r_err_q     <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
            r_m_req_q   <= w_m_req_d;
            r_m_wr_q    <= w_m_wr_d;
            r_m_addr_q  <= w_m_addr_d;
            r_m_dout_q  <= w_m_dout_d;
            r_src_ptr_q <= w_src_ptr_d;
            r_dst_ptr_q <= w_dst_ptr_d;
            r_rem_q     <= w_rem_d;
            r_chunk_q   <= w_chunk_d;
            r_idx_q     <= w_idx_d;
            r_buf_q     <= w_buf_d;
`ifdef BUS_COPY_GRANT_CHECK_EN
            r_err_q     <= w_err_d;
`endif
        end
    end

    assign busy   = r_busy_q;
    assign done   = r_done_q;
    assign m_req  = r_m_req_q;
    assign m_wr   = r_m_wr_q;
    assign m_addr = r_m_addr_q;
    assign m_dout = r_m_dout_q;
`ifdef BUS_COPY_GRANT_CHECK_EN
    assign err    = r_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_copy_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_copy_master
// Brief    : Self-checking bench for bus_copy_master with a slave/arbiter
//            model, a transaction-level expectation model and directed tests.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_copy_master;

    localparam int BUF_DEPTH = 4;
    localparam int LEN_W     = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [15:0]      src_addr;
    logic [15:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             m_req;
    logic             m_grant;
    logic             m_wr;
    logic [15:0]      m_addr;
    logic [63:0]      m_dout;
    logic [63:0]      m_din;
`ifdef BUS_COPY_GRANT_CHECK_EN
    logic             err;
`endif

    bus_copy_master #(.BUF_DEPTH(BUF_DEPTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
`ifdef BUS_COPY_GRANT_CHECK_EN
        .err      (err),
`endif
        .m_req    (m_req),
        .m_grant  (m_grant),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_din    (m_din)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave memory: unmapped addresses read as zero.
    logic [63:0] mem [logic [15:0]];
    function automatic logic [63:0] rd_mem(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 64'h0;
    endfunction

    // Arbiter grants one cycle after request; slave answers one cycle after address.
    logic        req_seen  = 1'b0;
    logic [15:0] addr_seen = 16'h0;
    bit          kill      = 1'b0;
    initial begin
        m_grant = 1'b0;
        m_din   = 64'h0;
        forever begin
            @(negedge clk);
            req_seen  = m_req;
            addr_seen = m_addr;
            @(posedge clk);
            #1;
            m_grant = req_seen && !kill;
            m_din   = rd_mem(addr_seen);
        end
    end

    typedef struct packed {
        logic [15:0] a;
        logic [63:0] d;
    } wr_t;

    wr_t exp_wq[$];
    wr_t wr_log[$];
    wr_t e;
    bit  chk_en      = 1'b1;
    bit  m_active    = 1'b0;
    bit  m_req_up    = 1'b0;
    int  m_start_cyc = 0;
    int  m_len       = 0;
    int  m_grant_cyc = -1;
    int  m_done_due  = -1;
    int  zero_due    = -1;
    int  done_cnt    = 0;
    int  last_grant_cyc = 0;
    int  last_done_cyc  = 0;

    // Compare process: transaction model says which writes, in order, and when done lands.
    initial forever begin
        @(negedge clk);
        if (reset === 1'b0) begin
            if (m_wr) wr_log.push_back({m_addr, m_dout});
            if (chk_en) begin
                if (m_active && m_grant_cyc < 0 && m_grant && busy) begin
                    m_grant_cyc    = cyc;
                    last_grant_cyc = cyc;
                    m_done_due     = cyc + 2 * m_len + (m_len + BUF_DEPTH - 1) / BUF_DEPTH + 1;
                end
                if (m_active && m_req) m_req_up = 1'b1;
                if (m_active && cyc > m_start_cyc && cyc != m_done_due)
                    chk("busy_during_copy", 64'(busy), 64'd1);
                if (m_active && m_req_up && exp_wq.size() > 0)
                    chk("req_held", 64'(m_req), 64'd1);
                if (m_wr) begin
                    chk("wr_has_req", 64'(m_req), 64'd1);
                    if (exp_wq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", m_addr, m_dout);
                    end else begin
                        e = exp_wq.pop_front();
                        chk("wr_addr", 64'(m_addr), 64'(e.a));
                        chk("wr_data", m_dout, e.d);
                    end
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    if (m_active && cyc == m_done_due) begin
                        chk("done_busy_low", 64'(busy), 64'd0);
                        chk("done_writes_left", 64'(exp_wq.size()), 64'd0);
                        m_active = 1'b0;
                    end else if (zero_due == cyc) begin
                        chk("zero_done_busy", 64'(busy), 64'd0);
                        zero_due = -1;
                    end else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected due %0d", cyc, m_done_due);
                    end
                end
                if (m_active && m_done_due >= 0 && cyc > m_done_due) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL done_missing: got no done, expected at cycle %0d", m_done_due);
                    m_active = 1'b0;
                end
                if (zero_due >= 0 && cyc > zero_due) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL zero_done_missing: got no done, expected at cycle %0d", zero_due);
                    zero_due = -1;
                end
            end
        end
    end

    task automatic copy_start(input logic [15:0] s, input logic [15:0] d, input int n);
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        if (chk_en && !m_active && zero_due < 0) begin
            if (n == 0) begin
                zero_due = cyc + 1;
            end else begin
                m_active    = 1'b1;
                m_start_cyc = cyc;
                m_len       = n;
                m_grant_cyc = -1;
                m_done_due  = -1;
                m_req_up    = 1'b0;
                for (int i = 0; i < n; i++)
                    exp_wq.push_back({d + 16'(i), rd_mem(s + 16'(i))});
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_quiet(input int max_cyc);
        int i = 0;
        while ((m_active || zero_due >= 0) && i < max_cyc) begin
            @(negedge clk);
            i++;
        end
        if (m_active || zero_due >= 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got copy still pending, expected completion within %0d cycles", max_cyc);
            m_active = 1'b0;
            zero_due = -1;
            exp_wq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        src_addr = 16'h0;
        dst_addr = 16'h0;
        len      = '0;
        mem[16'h00DF] = 64'd126;
        mem[16'h00E0] = 64'd1;
        mem[16'h00E1] = 64'd7;
        mem[16'hFFFE] = 64'hAAAA_0001;
        mem[16'hFFFF] = 64'hBBBB_0002;
        mem[16'h0000] = 64'hCCCC_0003;
        for (int i = 0; i < 8; i++) begin
            mem[16'h0100 + 16'(i)] = 64'h1000 + 64'(i);
            mem[16'h0200 + 16'(i)] = 64'h2000 + 64'(i);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy),   64'd0);
        chk("rst_done",   64'(done),   64'd0);
        chk("rst_req",    64'(m_req),  64'd0);
        chk("rst_wr",     64'(m_wr),   64'd0);
        chk("rst_addr",   64'(m_addr), 64'd0);
        chk("rst_dout",   m_dout,      64'd0);
`ifdef BUS_COPY_GRANT_CHECK_EN
        chk("rst_err",    64'(err),    64'd0);
`endif
        reset = 1'b0;

        // Single burst
        wr_log.delete();
        done_cnt = 0;
        copy_start(16'h00DF, 16'h7000, 3);
        wait_quiet(100);
        chk("sb_nwr", 64'(wr_log.size()), 64'd3);
        if (wr_log.size() == 3) begin
            chk("sb_a0", 64'(wr_log[0].a), 64'h7000);
            chk("sb_d0", wr_log[0].d, 64'd126);
            chk("sb_a1", 64'(wr_log[1].a), 64'h7001);
            chk("sb_d1", wr_log[1].d, 64'd1);
            chk("sb_a2", 64'(wr_log[2].a), 64'h7002);
            chk("sb_d2", wr_log[2].d, 64'd7);
        end
        chk("sb_latency", 64'(last_done_cyc - last_grant_cyc), 64'd8);
        chk("sb_done_cnt", 64'(done_cnt), 64'd1);

        // Multi burst, with an ignored start in the middle
        wr_log.delete();
        done_cnt = 0;
        copy_start(16'h0100, 16'h0A00, 6);
        repeat (3) @(negedge clk);
        copy_start(16'h0300, 16'h0B00, 2);
        wait_quiet(200);
        chk("mb_nwr", 64'(wr_log.size()), 64'd6);
        chk("mb_done_cnt", 64'(done_cnt), 64'd1);
        if (wr_log.size() == 6) begin
            chk("mb_a4", 64'(wr_log[4].a), 64'h0A04);
            chk("mb_d4", wr_log[4].d, 64'h1004);
            chk("mb_d5", wr_log[5].d, 64'h1005);
        end

        // Zero length
        wr_log.delete();
        done_cnt = 0;
        copy_start(16'h1234, 16'h5678, 0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_no_req", 64'(m_req), 64'd0);
        end
        wait_quiet(20);
        chk("zero_done_cnt", 64'(done_cnt), 64'd1);
        chk("zero_nwr", 64'(wr_log.size()), 64'd0);

        // Address wrap on both pointers
        wr_log.delete();
        copy_start(16'hFFFE, 16'hFFFF, 3);
        wait_quiet(100);
        chk("wrap_nwr", 64'(wr_log.size()), 64'd3);
        if (wr_log.size() == 3) begin
            chk("wrap_a0", 64'(wr_log[0].a), 64'hFFFF);
            chk("wrap_a1", 64'(wr_log[1].a), 64'h0000);
            chk("wrap_a2", 64'(wr_log[2].a), 64'h0001);
            chk("wrap_d0", wr_log[0].d, 64'hAAAA_0001);
            chk("wrap_d1", wr_log[1].d, 64'hBBBB_0002);
            chk("wrap_d2", wr_log[2].d, 64'hCCCC_0003);
        end

        // Reset in the middle of a copy, after three writes
        begin
            int w = 0;
            int i = 0;
            copy_start(16'h0200, 16'h0500, 8);
            while (w < 3 && i < 200) begin
                @(negedge clk);
                if (m_wr) w++;
                i++;
            end
            chk("rst_mid_writes_seen", 64'(w), 64'd3);
        end
        reset    = 1'b1;
        chk_en   = 1'b0;
        m_active = 1'b0;
        exp_wq.delete();
        @(posedge clk);
        #1;
        chk("rstm_req",  64'(m_req),  64'd0);
        chk("rstm_wr",   64'(m_wr),   64'd0);
        chk("rstm_busy", 64'(busy),   64'd0);
        chk("rstm_addr", 64'(m_addr), 64'd0);
        chk("rstm_done", 64'(done),   64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rstm_no_done", 64'(done), 64'd0);
            chk("rstm_no_req",  64'(m_req), 64'd0);
        end
        chk_en = 1'b1;

        // After reset: 4+1 bursts exercise the one-word final chunk
        wr_log.delete();
        copy_start(16'h0100, 16'h0800, 5);
        wait_quiet(100);
        chk("pr_nwr", 64'(wr_log.size()), 64'd5);
        if (wr_log.size() == 5) begin
            chk("pr_a4", 64'(wr_log[4].a), 64'h0804);
            chk("pr_d4", wr_log[4].d, 64'h1004);
        end

        // Single unmapped word reads as zero
        wr_log.delete();
        copy_start(16'h9000, 16'h0900, 1);
        wait_quiet(50);
        chk("um_nwr", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() == 1) chk("um_d0", wr_log[0].d, 64'h0);

`ifdef BUS_COPY_GRANT_CHECK_EN
        // Grant dropped during the second write cycle
        chk_en = 1'b0;
        begin
            int i = 0;
            copy_start(16'h0100, 16'h0C00, 4);
            while (!m_wr && i < 100) begin
                @(negedge clk);
                i++;
            end
            chk("gc_first_wr", 64'(m_wr), 64'd1);
        end
        kill = 1'b1;
        @(negedge clk);
        chk("gc_second_wr", 64'(m_wr),    64'd1);
        chk("gc_grant_low", 64'(m_grant), 64'd0);
        @(negedge clk);
        chk("gc_req",  64'(m_req), 64'd0);
        chk("gc_wr",   64'(m_wr),  64'd0);
        chk("gc_done", 64'(done),  64'd1);
        chk("gc_err",  64'(err),   64'd1);
        chk("gc_busy", 64'(busy),  64'd0);
        kill = 1'b0;
        repeat (3) @(negedge clk);
        chk("gc_err_sticky", 64'(err), 64'd1);
        copy_start(16'h0000, 16'h0000, 0);
        @(negedge clk);
        chk("gc_err_cleared", 64'(err),  64'd0);
        chk("gc_zero_done",   64'(done), 64'd1);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_copy_master.md
Name: bus_copy_master

Overview:
- Bus initiator that sits on the master side of the single-master BUS interconnect.
- Copies a block of 64-bit words from a source address range to a destination address range.
- Requests the bus, reads words into a small internal buffer in bursts, then writes them back out.
- Used to move data between slave 0 (memory) and slave 1 without CPU/testbench word-by-word driving.

Parameters:
- BUF_DEPTH, 4, internal word buffer depth = max burst length (power of 2, 2..16)
- LEN_W, 8, width of the length field in words

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; starts a copy when idle
- src_addr  input  16  first source word address, latched on start
- dst_addr  input  16  first destination word address, latched on start
- len  input  LEN_W  number of words to copy, latched on start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- m_req  output  1  bus request to BUS
- m_grant  input  1  bus grant from BUS
- m_wr  output  1  1 = write, 0 = read
- m_addr  output  16  bus address
- m_dout  output  64  write data to bus
- m_din  input  64  read data from bus

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: busy=0, done=0, m_req=0, m_wr=0, m_addr=16'h0000, m_dout=64'h0. Reset also clears the buffer index and the pointers. State returns to IDLE.
- Reset mid-operation: same-edge abort; m_req drops on that edge; no done pulse.
- Read latency is fixed at 1 cycle: m_din is sampled on the edge after the cycle m_addr was driven with m_wr=0.
- Registered outputs: m_addr, m_wr and m_dout are all registered.
- IDLE:
  - start with len != 0: latch src_ptr, dst_ptr and rem=len; set busy=1; go to REQ.
  - start with len == 0: done=1 next cycle, busy stays 0, no bus activity.
  - start while busy is ignored.
- REQ: m_req=1, m_wr=0. Wait here indefinitely until m_grant=1, then go to RD. chunk = min(rem, BUF_DEPTH).
- RD: lasts chunk cycles. Each cycle drives m_addr=src_ptr, m_wr=0, then src_ptr++. The word addressed in cycle k is captured into buf[k] one cycle later. After the chunk-th address, go to RD_TAIL.
- RD_TAIL: 1 cycle; captures the final word; m_addr holds its last value; m_wr=0.
- WR: lasts chunk cycles. Each cycle drives m_addr=dst_ptr, m_wr=1, m_dout=buf[k], then dst_ptr++ and rem--.
  - After the last write: if rem != 0, go to RD (m_req stays 1, no re-arbitration).
  - Otherwise go to FIN.
- FIN: m_req=0, m_wr=0, done=1 for exactly 1 cycle, busy=0 on the same edge; return to IDLE.
- m_req stays asserted continuously from REQ through the last WR cycle.
- Pointers are 16-bit and wrap: 16'hFFFF + 1 = 16'h0000. No range check; unmapped addresses simply read 0.
- Burst boundaries: len = BUF_DEPTH*n + r gives n full bursts, then a final burst of r words.
- m_dout holds the last written value outside WR. m_wr=0 in every state except WR.

Optional Feature:
- Macro: BUS_COPY_GRANT_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - If m_grant=0 in any RD, RD_TAIL or WR cycle, the transfer aborts: m_req=0, m_wr=0 next edge, err=1 sticky, done pulses, busy=0, go to IDLE.
  - err clears on the next accepted start.
- Not defined: no err port; m_grant is examined only in REQ.

Test Plan:
- Reset: reset=1 for 2 cycles mid-copy (after 3 writes of len=8) -> next edge m_req=0, m_wr=0, busy=0, m_addr=0; no done pulse.
- Single burst: src=16'h00DF, dst=16'h7000, len=3, grant 1 cycle after req, slave returns 126, 1, 7 -> m_wr=1 at 16'h7000..7002 with data 126, 1, 7. Done arrives 3+1+3+1 cycles after grant.
- Multi-burst: len=6, BUF_DEPTH=4 -> reads 4, writes 4, then reads 2, writes 2. m_req never drops between bursts; done pulses once.
- Edge cases: len=0 -> done next cycle, m_req never asserts. Start while busy -> ignored, latched values unchanged.
- Address wrap: src=16'hFFFE, len=3 -> read addresses FFFE, FFFF, 0000; dst pointer wraps the same way.
- BUS_COPY_GRANT_CHECK_EN defined: drop m_grant during the 2nd WR cycle -> err=1, done pulse, m_req=0 next edge; a new start clears err.
